// File: rtl/spi_slave_fifo.sv
// Buffered SPI slave: synchronised pins, mode/bit-order select and TX/RX FIFOs
// behind valid/ready handshakes, all in the system clock domain.

module spi_slave_fifo_buf #(
  parameter int W  = 16,
  parameter int D  = 4,
  parameter int LW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;

  // Storage carries no reset so it can map onto RAM; the empty gate hides stale data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + LW'(wr_en) - LW'(rd_en);
    end
  end

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == LW'(D));
  assign level   = count_reg;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
endmodule

module spi_slave_fifo #(
  parameter int K_DWIDTH      = 16,
  parameter int K_FIFO_DEPTH  = 4,
  parameter int K_SYNC_STAGES = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [K_DWIDTH-1:0]               i_tx_data,
  input  logic                              i_tx_valid,
  output logic                              o_tx_ready,
  output logic [K_DWIDTH-1:0]               o_rx_data,
  output logic                              o_rx_valid,
  input  logic                              i_rx_ready,
  output logic [$clog2(K_FIFO_DEPTH+1)-1:0] o_tx_level,
  output logic [$clog2(K_FIFO_DEPTH+1)-1:0] o_rx_level,
  output logic                              o_rx_overflow,
  output logic                              o_tx_underrun,
  input  logic                              i_clr_flags,
  input  logic                              i_cpol,
  input  logic                              i_cpha,
  input  logic                              i_lsb_first,
  output logic                              o_selected,
  input  logic                              i_spi_clk,
  input  logic                              i_cs_n,
  input  logic                              i_mosi,
  output logic                              o_miso
);
  localparam int W  = K_DWIDTH;
  localparam int S  = K_SYNC_STAGES;
  localparam int CW = $clog2(W);
  localparam int LW = $clog2(K_FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [S-1:0]  sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic          sck_prev_reg, lead_reg, trail_reg, mosi_reg, sel_prev_reg;
  state_t        state_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic [W-1:0]  rx_shift_reg, tx_shift_reg;
  logic          miso_reg, ovf_reg, unr_reg;

  logic          sck_s, selected, sel_rise, cap_evt, shift_evt;
  logic          word_done, load_evt;
  logic [W-1:0]  rx_word_next, tx_head, rx_head;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, ovf_set, unr_set;
  logic [LW-1:0] tx_level, rx_level;

  function automatic logic first_bit(input logic [W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[W-1];
  endfunction

  function automatic logic [W-1:0] drop_bit(input logic [W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign sck_s     = sck_sync_reg[S-1];
  assign selected  = ~cs_sync_reg[S-1];
  assign sel_rise  = selected & ~sel_prev_reg;
  assign cap_evt   = selected & (i_cpha ? trail_reg : lead_reg);
  assign shift_evt = selected & (i_cpha ? lead_reg : trail_reg);

  assign rx_word_next = i_lsb_first ? {mosi_reg, rx_shift_reg[W-1:1]}
                                    : {rx_shift_reg[W-2:0], mosi_reg};
  assign word_done = (state_reg == SHIFT) & cap_evt & (bit_cnt_reg == LAST_BIT);
  assign load_evt  = (state_reg == LOAD) | word_done;

  assign tx_push = i_tx_valid & ~tx_full;
  assign tx_pop  = load_evt & ~tx_empty;
  assign unr_set = load_evt & tx_empty;
  // A same-cycle pop frees a slot, so a full RX FIFO still accepts the word.
  assign rx_pop  = i_rx_ready & ~rx_empty;
  assign rx_push = word_done & (~rx_full | rx_pop);
  assign ovf_set = word_done & rx_full & ~rx_pop;

  spi_slave_fifo_buf #(.W(W), .D(K_FIFO_DEPTH)) u_tx_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .wr_en(tx_push), .wr_data(i_tx_data),
    .rd_en(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty),
    .level(tx_level)
  );

  spi_slave_fifo_buf #(.W(W), .D(K_FIFO_DEPTH)) u_rx_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .wr_en(rx_push), .wr_data(rx_word_next),
    .rd_en(rx_pop), .rd_data(rx_head), .full(rx_full), .empty(rx_empty),
    .level(rx_level)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_sync_reg  <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sck_prev_reg  <= 1'b0;
      lead_reg      <= 1'b0;
      trail_reg     <= 1'b0;
      mosi_reg      <= 1'b0;
      sel_prev_reg  <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[S-2:0], i_spi_clk};
      cs_sync_reg   <= {cs_sync_reg[S-2:0], i_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[S-2:0], i_mosi};
      sck_prev_reg  <= sck_s;
      // Edge pulses and MOSI are registered together so capture sees matching data.
      lead_reg      <= (sck_s != i_cpol) & (sck_prev_reg == i_cpol);
      trail_reg     <= (sck_s == i_cpol) & (sck_prev_reg != i_cpol);
      mosi_reg      <= mosi_sync_reg[S-1];
      sel_prev_reg  <= selected;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      miso_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (sel_rise) state_reg <= LOAD;
        LOAD: begin
          state_reg   <= SHIFT;
          bit_cnt_reg <= '0;
        end
        SHIFT: begin
          if (!selected) begin
            state_reg <= IDLE;
          end else if (cap_evt) begin
            rx_shift_reg <= rx_word_next;
            bit_cnt_reg  <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + CW'(1);
          end else if (shift_evt && (i_cpha || bit_cnt_reg != '0)) begin
            // In CPHA=0 the shift edge right after the final capture must not advance.
            miso_reg     <= first_bit(tx_shift_reg, i_lsb_first);
            tx_shift_reg <= drop_bit(tx_shift_reg, i_lsb_first);
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (load_evt) begin
        if (!i_cpha) begin
          miso_reg     <= first_bit(tx_head, i_lsb_first);
          tx_shift_reg <= drop_bit(tx_head, i_lsb_first);
        end else begin
          tx_shift_reg <= tx_head;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_reg <= 1'b0;
      unr_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_set | (ovf_reg & ~i_clr_flags);
      unr_reg <= unr_set | (unr_reg & ~i_clr_flags);
    end
  end

  assign o_tx_ready    = ~tx_full;
  assign o_tx_level    = tx_level;
  assign o_rx_valid    = ~rx_empty;
  assign o_rx_data     = rx_head;
  assign o_rx_level    = rx_level;
  assign o_rx_overflow = ovf_reg;
  assign o_tx_underrun = unr_reg;
  assign o_selected    = selected;
  assign o_miso        = miso_reg;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Randomised bench for spi_slave_fifo: a bit-banged SPI master plus a queue
// model of both FIFOs, the per-load TX consumption and the sticky flags.

module tb_spi_slave_fifo;
  localparam int W    = 16;
  localparam int D    = 4;
  localparam int S    = 2;
  localparam int LW   = $clog2(D + 1);
  localparam int HALF = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [LW-1:0] tx_level, rx_level;
  logic          rx_overflow, tx_underrun;
  logic          clr_flags = 1'b0;
  logic          cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic          selected;
  logic          spi_clk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic          miso;

  always #5 clk = ~clk;

  spi_slave_fifo #(.K_DWIDTH(W), .K_FIFO_DEPTH(D), .K_SYNC_STAGES(S)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_tx_level(tx_level), .o_rx_level(rx_level),
    .o_rx_overflow(rx_overflow), .o_tx_underrun(tx_underrun),
    .i_clr_flags(clr_flags), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb_first), .o_selected(selected),
    .i_spi_clk(spi_clk), .i_cs_n(cs_n), .i_mosi(mosi), .o_miso(miso)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];
  logic         exp_ovf = 1'b0;
  logic         exp_unr = 1'b0;
  logic [W-1:0] cur_tx = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_tx_level"}, 32'(tx_level), 32'(tx_q.size()));
    chk({tag, "_rx_level"}, 32'(rx_level), 32'(rx_q.size()));
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'(tx_q.size() < D));
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'(rx_q.size() > 0));
    chk({tag, "_overflow"}, 32'(rx_overflow), 32'(exp_ovf));
    chk({tag, "_underrun"}, 32'(tx_underrun), 32'(exp_unr));
  endtask

  task automatic set_mode(input logic [2:0] m);
    @(negedge clk);
    {cpol, cpha, lsb_first} = m;
    spi_clk = m[2];
    cycles(8);
  endtask

  task automatic push_tx(input logic [W-1:0] w);
    @(negedge clk);
    chk("push_ready", 32'(tx_ready), 32'(tx_q.size() < D));
    tx_valid = 1'b1;
    tx_data  = w;
    @(negedge clk);
    tx_valid = 1'b0;
    if (tx_q.size() < D) tx_q.push_back(w);
  endtask

  task automatic pop_rx();
    logic [W-1:0] exp_w;
    exp_w = rx_q.pop_front();
    @(negedge clk);
    chk("pop_valid", 32'(rx_valid), 32'd1);
    chk("pop_data", 32'(rx_data), 32'(exp_w));
    $display("pop rx_data=0x%04h expected=0x%04h", rx_data, exp_w);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    exp_ovf = 1'b0;
    exp_unr = 1'b0;
  endtask

  // Every load (frame start and every completed word) consumes one TX entry.
  task automatic model_load();
    if (tx_q.size() > 0) begin
      cur_tx = tx_q.pop_front();
    end else begin
      cur_tx  = '0;
      exp_unr = 1'b1;
    end
  endtask

  task automatic cs_assert();
    model_load();
    @(negedge clk);
    cs_n = 1'b0;
    cycles(HALF);
    chk("selected", 32'(selected), 32'd1);
  endtask

  task automatic cs_release();
    cycles(HALF);
    cs_n = 1'b1;
    cycles(HALF);
  endtask

  task automatic spi_bits(input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
    int idx;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb_first ? i : W - 1 - i;
      if (!cpha) begin
        mosi = tx[idx];
        cycles(HALF);
        spi_clk = ~cpol;
        rx[idx] = miso;
        cycles(HALF);
        spi_clk = cpol;
      end else begin
        spi_clk = ~cpol;
        mosi = tx[idx];
        cycles(HALF);
        spi_clk = cpol;
        rx[idx] = miso;
        cycles(HALF);
      end
    end
  endtask

  task automatic xfer_word(input logic [W-1:0] m);
    logic [W-1:0] got;
    spi_bits(m, W, got);
    chk("miso_word", 32'(got), 32'(cur_tx));
    $display("word mode=%0d%0d%0d mosi=0x%04h miso=0x%04h expected_miso=0x%04h",
             cpol, cpha, lsb_first, m, got, cur_tx);
    if (rx_q.size() < D) rx_q.push_back(m);
    else exp_ovf = 1'b1;
    model_load();
    cycles(2);
    check_status("word");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_tx_level"}, 32'(tx_level), 32'd0);
    chk({tag, "_rx_level"}, 32'(rx_level), 32'd0);
    chk({tag, "_overflow"}, 32'(rx_overflow), 32'd0);
    chk({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_selected"}, 32'(selected), 32'd0);
  endtask

  initial begin
    logic [W-1:0] r1, r2, dummy;
    cycles(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    cycles(6);
    check_reset_outputs("post_rst");

    // Mode 0, MSB first, single frame
    set_mode(3'b000);
    push_tx(16'hA55A);
    check_status("pushed");
    cs_assert();
    xfer_word(16'h1234);
    cs_release();
    pop_rx();
    check_status("t1_done");

    // All modes, two back-to-back words each
    for (int m = 0; m < 8; m++) begin
      clear_flags();
      set_mode(3'(m));
      r1 = W'($urandom);
      r2 = W'($urandom);
      push_tx(16'h8001);
      push_tx(r1);
      cs_assert();
      xfer_word(16'h00FF);
      xfer_word(r2);
      cs_release();
      pop_rx();
      pop_rx();
    end

    // Three back-to-back frames without CS toggle
    clear_flags();
    set_mode(3'b000);
    push_tx(16'h1111);
    push_tx(16'h2222);
    push_tx(16'h3333);
    cs_assert();
    xfer_word(16'hAAAA);
    xfer_word(16'hBBBB);
    xfer_word(16'hCCCC);
    cs_release();
    chk("b2b_rx_level", 32'(rx_level), 32'd3);
    for (int i = 0; i < 3; i++) pop_rx();

    // TX FIFO full, then drained by a D-word frame in a random mode
    clear_flags();
    set_mode(3'($urandom_range(0, 7)));
    for (int i = 0; i <= D; i++) push_tx(W'($urandom));
    check_status("tx_full");
    cs_assert();
    for (int i = 0; i < D; i++) xfer_word(W'($urandom));
    cs_release();
    for (int i = 0; i < D; i++) pop_rx();

    // RX overflow: five words with no pops
    clear_flags();
    set_mode(3'($urandom_range(0, 7)));
    for (int f = 0; f < 5; f++) begin
      cs_assert();
      xfer_word(W'($urandom));
      cs_release();
    end
    check_status("ovf");
    chk("ovf_rx_level", 32'(rx_level), 32'd4);
    clear_flags();
    check_status("ovf_cleared");
    for (int i = 0; i < D; i++) pop_rx();

    // Underrun: frame with empty TX FIFO
    clear_flags();
    cs_assert();
    xfer_word(W'($urandom));
    cs_release();
    chk("unr_flag", 32'(tx_underrun), 32'd1);
    pop_rx();

    // Abort after 7 bits, then a clean frame must start at bit 0
    clear_flags();
    set_mode(3'($urandom_range(0, 7)));
    push_tx(W'($urandom));
    cs_assert();
    spi_bits(W'($urandom), 7, dummy);
    cs_release();
    check_status("abort");
    push_tx(W'($urandom));
    cs_assert();
    xfer_word(W'($urandom));
    cs_release();
    pop_rx();

    // Asynchronous reset in the middle of a frame
    push_tx(W'($urandom));
    push_tx(W'($urandom));
    cs_assert();
    spi_bits(W'($urandom), 5, dummy);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    cs_n = 1'b1;
    spi_clk = cpol;
    mosi = 1'b0;
    tx_q.delete();
    rx_q.delete();
    exp_ovf = 1'b0;
    exp_unr = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(6);
    check_status("after_rst");
    push_tx(W'($urandom));
    push_tx(W'($urandom));
    cs_assert();
    xfer_word(W'($urandom));
    cs_release();
    pop_rx();
    check_status("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
